// File: rtl/csa_issue_ctrl.sv
// Issue/return controller for a fixed-latency carry-select adder: registers operands,
// tracks in-flight operations and buffers results in a credit-protected FIFO.
module csa_issue_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  output logic [WIDTH-1:0] add_op1,
  output logic [WIDTH-1:0] add_op2,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_crout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_crout,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             crout;
    logic [WIDTH-1:0] sum;
  } result_t;

  result_t       mem [DEPTH];
  logic [LAT:0]  vpipe;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          pop;
  logic          wr_en;

  // Credits cover in-flight plus buffered results, so a write never finds the FIFO full.
  assign in_ready  = (cnt < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = vpipe[LAT];
  assign busy      = (cnt != '0);
  assign out_sum   = mem[rd_ptr].sum;
  assign out_crout = mem[rd_ptr].crout;

  // Operand registers feeding the adder; hold when nothing is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      add_op1 <= '0;
      add_op2 <= '0;
    end else if (accept) begin
      add_op1 <= in_op1;
      add_op2 <= in_op2;
    end
  end

  // Valid shadow of the adder pipeline (LAT must be at least 1).
  always_ff @(posedge clock) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-1:0], accept};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{crout: add_crout, sum: add_sum};
    end
  end

endmodule

// File: tb/tb_csa_issue_ctrl.sv
// Randomized scoreboard bench for csa_issue_ctrl with a behavioural adder and a
// transaction-level model of acceptance, latency and ordering.
module tb_csa_issue_ctrl;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_op1 = '0;
  logic [WIDTH-1:0] in_op2 = '0;
  logic [WIDTH-1:0] add_op1;
  logic [WIDTH-1:0] add_op2;
  logic [WIDTH-1:0] add_sum;
  logic             add_crout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_crout;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             crout;
    int               rdy;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               n_acc = 0;
  int               n_pop = 0;
  logic             mon_pop = 1'b0;
  int               mode = 1;
  logic [WIDTH-1:0] last_op1 = '0;
  logic [WIDTH-1:0] last_op2 = '0;
  logic [WIDTH:0]   apipe [LAT];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  csa_issue_ctrl #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
    .add_op1(add_op1), .add_op2(add_op2), .add_sum(add_sum), .add_crout(add_crout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_crout(out_crout),
    .busy(busy)
  );

  // Adder: sum register updates LAT edges after the operand register captures.
  always @(posedge clock) begin
    apipe[0] <= {1'b0, add_op1} + {1'b0, add_op2};
    for (int i = 1; i < int'(LAT); i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum   = apipe[LAT-1][WIDTH-1:0];
  assign add_crout = apipe[LAT-1][WIDTH];

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: head of the scoreboard becomes visible at its ready cycle and leaves on out_ready.
  always @(negedge clock) begin
    logic vis;
    mon_pop = 1'b0;
    if (!reset) begin
      vis = (sb.size() > 0) && (sb[0].rdy <= cyc);
      chk("out_valid", {{WIDTH{1'b0}}, out_valid}, {{WIDTH{1'b0}}, vis});
      if (vis) begin
        chk("out_sum", {1'b0, out_sum}, {1'b0, sb[0].sum});
        chk("out_crout", {{WIDTH{1'b0}}, out_crout}, {{WIDTH{1'b0}}, sb[0].crout});
        if (out_ready) begin
          void'(sb.pop_front());
          mon_pop = 1'b1;
          n_pop++;
        end
      end
    end
  end

  // One clock of stimulus; acceptance decided by the credit model (accepted minus popped).
  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      output logic acc);
    int             exp_cnt;
    logic [WIDTH:0] full;
    in_valid  = v;
    in_op1    = a;
    in_op2    = b;
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    @(negedge clock);
    #1;
    exp_cnt = n_acc - (n_pop - int'(mon_pop));
    chk("in_ready", {{WIDTH{1'b0}}, in_ready}, {{WIDTH{1'b0}}, exp_cnt < int'(DEPTH)});
    chk("busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, exp_cnt != 0});
    chk("add_op1", {1'b0, add_op1}, {1'b0, last_op1});
    chk("add_op2", {1'b0, add_op2}, {1'b0, last_op2});
    acc = v && (exp_cnt < int'(DEPTH));
    if (acc) begin
      full = {1'b0, a} + {1'b0, b};
      sb.push_back('{sum: full[WIDTH-1:0], crout: full[WIDTH], rdy: cyc + int'(LAT) + 2});
      n_acc++;
      last_op1 = a;
      last_op2 = b;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, a, b, acc);
      tries++;
    end
    chk("send_timeout", {{WIDTH{1'b0}}, acc}, {{WIDTH{1'b0}}, 1'b1});
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, '0, '0, acc);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op1   = {$urandom, $urandom};
    in_op2   = {$urandom, $urandom};
    repeat (n) begin
      @(negedge clock);
      #1;
      sb.delete();
      n_acc    = 0;
      n_pop    = 0;
      last_op1 = '0;
      last_op2 = '0;
      @(posedge clock);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    int   guard;
    do_reset(3);
    idle(2);

    // Single op with carry out
    mode = 1;
    send({WIDTH{1'b1}}, 64'h1);
    idle(6);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) send(64'(i), 64'(2 * i));
    idle(6);

    // Backpressure: four fill the credits, the fifth waits for a pop
    mode = 0;
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) step(1'b1, 64'h55, 64'hAA, acc);
    mode = 1;
    send(64'h55, 64'hAA);

    // Full FIFO with continuous offer and drain
    for (int i = 0; i < 12; i++) send({$urandom, $urandom}, {$urandom, $urandom});
    idle(8);

    // Reset with an operation in flight
    send(64'h5, 64'h7);
    do_reset(1);
    idle(8);

    // Random traffic across several pointer wraps
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      else if (i == 6) send({WIDTH{1'b1}}, {WIDTH{1'b1}});
      else step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom}, acc);
    end

    mode  = 1;
    guard = 0;
    while (n_pop != n_acc && guard < 60) begin
      idle(1);
      guard++;
    end
    chk("drain", {{WIDTH{1'b0}}, n_pop == n_acc}, {{WIDTH{1'b0}}, 1'b1});
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
